// File: rtl/mc_controller_pkg.sv
// Shared MIPS multicycle declarations: opcodes, controller states, ALU op codes.
// The BNE state only exists when MC_BNE_EN is defined.
package mips_decls_p;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12
`ifdef MC_BNE_EN
    , S_BNE   = 4'd13
`endif
  } mc_state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Anything not listed here is flagged as illegal in DECODE.
  function automatic logic op_implemented(opcode_t op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
`ifdef MC_BNE_EN
      OP_BNE: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control lines out.
interface mc_controller_if;
  import mips_decls_p::*;

  opcode_t     opcode;
  logic [5:0]  funct;
  logic        zero;

  logic        pcen;
  logic        iord;
  logic        memwrite;
  logic        irwrite;
  logic        regdst;
  logic        memtoreg;
  logic        regwrite;
  logic        alusrca;
  logic        zeroext;
  logic [1:0]  alusrcb;
  logic [1:0]  pcsrc;
  logic [2:0]  alucontrol;
  logic        illegal;

  modport master (
    input  opcode, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, zeroext, alusrcb, pcsrc, alucontrol, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, zeroext, alusrcb, pcsrc, alucontrol, illegal
  );
endinterface

// File: rtl/mc_controller_aludec.sv
// ALU decoder: turns the FSM's aluop plus the R-type funct field into an ALU operation.
module aludec
  import mips_decls_p::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_OR:  alucontrol = ALU_OR;
      default: begin
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = 3'bxxx;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore FSM sequencing the shared multicycle MIPS datapath.
// Define MC_BNE_EN to add the BNE instruction; otherwise OP_BNE decodes as illegal.
module mc_controller
  import mips_decls_p::*;
(
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  mc_state_t  state, next_state, cur;
  logic       pcwrite, branch, branchne;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, zeroext;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [2:0] alucontrol;
  logic       illegal;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BEQ;
`ifdef MC_BNE_EN
          OP_BNE:       next_state = S_BNE;
`endif
          OP_ADDI:      next_state = S_ADDIEX;
          OP_ORI:       next_state = S_ORIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = S_MEMWB;
      S_EXECUTE: next_state = S_ALUWB;
      S_ADDIEX:  next_state = S_IMMWB;
      S_ORIEX:   next_state = S_IMMWB;
      default:   next_state = S_FETCH;
    endcase
  end

  // While reset is held the outputs look like FETCH even if the register
  // still holds a mid-instruction state; write strobes are then suppressed.
  assign cur = reset ? S_FETCH : state;

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchne = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    zeroext  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    case (cur)
      S_FETCH:   begin irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR,
      S_ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_ORIEX:   begin alusrca = 1'b1; alusrcb = 2'b10; zeroext = 1'b1; aluop = ALUOP_OR; end
      S_MEMRD:   iord = 1'b1;
      S_MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      S_MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
      S_EXECUTE: begin alusrca = 1'b1; aluop = ALUOP_FUNCT; end
      S_ALUWB:   begin regdst = 1'b1; regwrite = 1'b1; end
      S_IMMWB:   regwrite = 1'b1;
      S_BEQ:     begin alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = 2'b01; branch = 1'b1; end
`ifdef MC_BNE_EN
      S_BNE:     begin alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = 2'b01; branchne = 1'b1; end
`endif
      S_JUMP:    begin pcsrc = 2'b10; pcwrite = 1'b1; end
      default:   ;
    endcase
    if (reset) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign illegal = !reset && (state == S_DECODE) && !op_implemented(bus.opcode);

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol)
  );

  assign bus.pcen       = pcwrite | (branch & bus.zero) | (branchne & ~bus.zero);
  assign bus.iord       = iord;
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.zeroext    = zeroext;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.illegal    = illegal;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: none; all widths fixed by mips_decls_p.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  opcode_t(6)  instr[31:26] from instruction register.
REQ-005 funct  input  6  instr[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pcen  output  1  PC register enable.
REQ-008 iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, zeroext  output  1 each  datapath controls.
REQ-009 alusrcb, pcsrc  output  2 each  mux selects.
REQ-010 alucontrol  output  3  ALU operation.
REQ-011 illegal  output  1  one-cycle pulse on unimplemented opcode.

Function
REQ-012 The block SHALL be a Moore FSM that sequences the shared multicycle datapath; outputs depend only on the state, except pcen, alucontrol and illegal.
REQ-013 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQ, BNE, ADDIEX, ORIEX, IMMWB, JUMP.
REQ-014 Transitions SHALL be: FETCH->DECODE; DECODE by opcode: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BEQ, BNE->BNE, ADDI->ADDIEX, ORI->ORIEX, J->JUMP, other->FETCH; MEMADR->MEMRD (LW) or MEMWR (SW); MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX, ORIEX->IMMWB; all other states->FETCH.
REQ-015 Outputs not listed for a state SHALL be 0.
REQ-016 FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
REQ-017 DECODE: alusrcb=11, aluop=00.
REQ-018 MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00. ORIEX: the same, plus zeroext=1, aluop=11.
REQ-019 MEMRD: iord=1. MEMWR: iord=1, memwrite=1. MEMWB: memtoreg=1, regwrite=1.
REQ-020 EXECUTE: alusrca=1, aluop=10. ALUWB: regdst=1, regwrite=1. IMMWB: regwrite=1.
REQ-021 BEQ: alusrca=1, aluop=01, pcsrc=01, branch=1. BNE: the same, but branchne=1 instead of branch=1.
REQ-022 JUMP: pcsrc=10, pcwrite=1.
REQ-023 pcen SHALL equal pcwrite | (branch & zero) | (branchne & ~zero), combinationally.
REQ-024 alucontrol SHALL be decoded from aluop and funct: 00->010 (add), 01->110 (sub), 11->001 (or), 10->by funct (add 010, sub 110, and 000, or 001, slt 111, other xxx).
REQ-025 Cycle counts SHALL be: LW 5; SW, RTYPE, ADDI, ORI 4; BEQ, BNE, J 3; illegal 2.
REQ-026 illegal SHALL be 1 only in DECODE with an unimplemented opcode. The next state is FETCH, and no write strobe is asserted.

Reset
REQ-027 reset=1 at a clock edge SHALL force state=FETCH, from any state, including mid-instruction.
REQ-028 While reset=1, pcwrite, pcen, irwrite, memwrite and regwrite SHALL be forced to 0. All other outputs SHALL take their FETCH values.
REQ-029 The first FETCH after reset deasserts SHALL behave as a normal fetch.

Configuration
REQ-030 With macro MC_BNE_EN defined, BNE SHALL be supported per REQ-014/021.
REQ-031 Without MC_BNE_EN, the BNE state SHALL be absent, OP_BNE SHALL be treated as illegal, and branchne SHALL be tied to 0.

Structure
REQ-032 The opcode_t enum, the state enum mc_state_t (4-bit) and the aluop encodings SHALL reside in mips_decls_p.
REQ-033 Decoding of alucontrol SHALL be a separate sub-module, aludec, instantiated once.
REQ-034 Only the state register SHALL be sequential; next-state and output logic SHALL be always_comb.

Verification
REQ-035 Reset for 2 cycles in state MEMRD, then release -> state=FETCH; irwrite=0 and pcen=0 during reset; first post-reset cycle irwrite=1, pcen=1, alusrcb=01.
REQ-036 opcode=LW (100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-037 opcode=RTYPE, funct=101010 -> EXECUTE shows alucontrol=111; ALUWB shows regdst=1, regwrite=1; 4 cycles total.
REQ-038 opcode=BEQ with zero=1, then with zero=0 -> pcen=1 in the BEQ cycle, then pcen=0; pcsrc=01; returns to FETCH.
REQ-039 opcode=ORI (001101) -> ORIEX shows zeroext=1, alucontrol=001; IMMWB shows regwrite=1, regdst=0.
REQ-040 opcode=111111 -> illegal=1 for one cycle in DECODE, no write strobes, next state FETCH. BNE with zero=0: with MC_BNE_EN pcen=1; without MC_BNE_EN illegal=1.
